pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be: FLAG 2 (PC command width); ADDR 20 (address width); STACK_DEPTH 4 (call-stack entries, used only with PC_SEQ_CALL_STACK_EN).
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 start  in  1  begin or resume execution; sampled in IDLE and HALT only.
REQ-005 pc_address  in  ADDR  current program-counter value.
REQ-006 mem_ready  in  1  instruction memory output valid.
REQ-007 ctl_kind  in  3  decoded control type: 0 seq, 1 jump, 2 branch, 3 jr, 4 call, 5 ret, 6 halt, 7 reserved.
REQ-008 branch_taken  in  1  branch condition result.
REQ-009 target_addr  in  ADDR  jump/branch/call target.
REQ-010 reg_addr  in  ADDR  jump-register value.
REQ-011 flagPC  out  FLAG  PC command: 0 hold, 1 increment, 2 load newAddress.
REQ-012 newAddress  out  ADDR  PC load value.
REQ-013 pc_clear  out  1  drives PC synchronous clear.
REQ-014 ir_load  out  1  latch instruction register.
REQ-015 exec_en  out  1  datapath execute strobe.
REQ-016 halted  out  1  high in HALT.
REQ-017 state  out  3  current state encoding (debug).
REQ-018 stack_err  out  1  sticky call-stack overflow/underflow flag.

Function
REQ-019 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, UPDATE=4, HALT=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-020 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.
REQ-021 IDLE: pc_clear=1, flagPC=0; start=1 -> FETCH.
REQ-022 FETCH: mem_ready=0 -> stay, flagPC=0; mem_ready=1 -> ir_load=1 that cycle, next DECODE.
REQ-023 DECODE: one cycle, no strobes, next EXECUTE.
REQ-024 EXECUTE: exec_en=1 for exactly one cycle; sample ctl_kind, branch_taken, target_addr, reg_addr, pc_address; next UPDATE, or HALT for ctl_kind=6.
REQ-025 UPDATE: one cycle driving flagPC/newAddress from EXECUTE samples; next FETCH.
REQ-026 flagPC SHALL be nonzero only in UPDATE; newAddress SHALL be 0 whenever flagPC!=2.
REQ-027 UPDATE mapping: seq -> 1; jump -> 2/target; branch taken -> 2/target, not taken -> 1; jr -> 2/reg_addr; reserved -> 1.
REQ-028 Minimum instruction period SHALL be 4 cycles (FETCH..UPDATE) with mem_ready held high.
REQ-029 HALT: halted=1, flagPC=0; start=1 -> FETCH with PC unchanged (resumes at halt address).
REQ-030 start outside IDLE/HALT SHALL be ignored.
REQ-031 Return address SHALL be pc_address+1 modulo 2^ADDR (0xFFFFF -> 0x00000).

Reset
REQ-032 reset=0 SHALL asynchronously force: state IDLE, flagPC 0, newAddress 0, pc_clear 1, ir_load/exec_en/halted 0, stack_err 0, stack empty.
REQ-033 Reset asserted mid-instruction (including UPDATE) SHALL abort without any PC command issued.
REQ-034 After reset release, IDLE SHALL hold until start=1.

Configuration
REQ-035 Macro PC_SEQ_CALL_STACK_EN defined: STACK_DEPTH-entry LIFO; call pushes return address in EXECUTE and loads target (flagPC=2); ret pops and loads top (flagPC=2).
REQ-036 With macro: call with stack full -> jump taken, push dropped, stack_err=1; ret with stack empty -> flagPC=1, stack_err=1; stack_err clears only on reset.
REQ-037 Macro undefined: call behaves as jump, ret as seq, stack_err tied 0, no stack storage.

Verification
REQ-038 Reset release, start=1, mem_ready=1, ctl_kind=0 -> pc_clear drops, flagPC=1 every 4th cycle, exactly one cycle wide.
REQ-039 mem_ready low 3 cycles in FETCH -> state=1 held 3 extra cycles, ir_load only on ready cycle, flagPC=0 throughout.
REQ-040 ctl_kind=2, target 0x00123, branch_taken=1 then 0 -> UPDATE flagPC=2/newAddress=0x00123, then flagPC=1/newAddress=0.
REQ-041 Macro on: call at pc 0xFFFFF to 0x00010, then ret -> second UPDATE flagPC=2/newAddress=0x00000; five nested calls -> stack_err=1 on fifth.
REQ-042 ctl_kind=6 -> halted=1, flagPC=0 indefinitely; start=1 -> FETCH, first later UPDATE relative to halt-address PC.
REQ-043 reset=0 during EXECUTE of jump to 0x00050 -> immediate IDLE, no flagPC=2 cycle, pc_clear=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer. It steps through
// IDLE -> FETCH -> DECODE -> EXECUTE -> UPDATE and issues one PC command
// per instruction. It can park in HALT and resume from there.
//
// Optional feature: define PC_SEQ_CALL_STACK_EN to add a STACK_DEPTH-entry
// return-address LIFO for call/ret. Without it, call acts as jump, ret acts
// as seq, and stack_err is tied low.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   start        begin/resume; honoured only in IDLE and HALT
//   pc_address   current PC value (sampled in EXECUTE)
//   mem_ready    instruction memory output valid (FETCH handshake)
//   ctl_kind     0 seq, 1 jump, 2 branch, 3 jr, 4 call, 5 ret, 6 halt, 7 rsvd
//   branch_taken branch condition result
//   target_addr  jump/branch/call target
//   reg_addr     jump-register value
//   flagPC       PC command: 0 hold, 1 increment, 2 load newAddress
//   newAddress   PC load value (zero unless flagPC==2)
//   pc_clear     PC synchronous clear (high in IDLE)
//   ir_load      instruction register latch strobe
//   exec_en      datapath execute strobe (EXECUTE)
//   halted       high in HALT
//   state        current state code (debug)
//   stack_err    sticky call-stack overflow/underflow flag
//
// Every output is registered. Each output is computed on the same edge that
// enters the state it belongs to. ir_load is therefore captured on the edge
// that sees mem_ready in FETCH. It is high for one cycle, the first DECODE
// cycle, so that no path exists from mem_ready to the output.
module pc_sequencer #(
    parameter int unsigned FLAG        = 2,
    parameter int unsigned ADDR        = 20,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR-1:0] pc_address,
    input  logic            mem_ready,
    input  logic [2:0]      ctl_kind,
    input  logic            branch_taken,
    input  logic [ADDR-1:0] target_addr,
    input  logic [ADDR-1:0] reg_addr,
    output logic [FLAG-1:0] flagPC,
    output logic [ADDR-1:0] newAddress,
    output logic            pc_clear,
    output logic            ir_load,
    output logic            exec_en,
    output logic            halted,
    output logic [2:0]      state,
    output logic            stack_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_UPDATE  = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_SEQ    = 3'd0,
        K_JUMP   = 3'd1,
        K_BRANCH = 3'd2,
        K_JR     = 3'd3,
        K_CALL   = 3'd4,
        K_RET    = 3'd5,
        K_HALT   = 3'd6,
        K_RSVD   = 3'd7
    } ctl_t;

    typedef enum logic [FLAG-1:0] {
        PC_HOLD = FLAG'(0),
        PC_INC  = FLAG'(1),
        PC_LOAD = FLAG'(2)
    } pc_cmd_t;

    state_t cur;

    assign state = cur;

`ifdef PC_SEQ_CALL_STACK_EN
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0] sp;
    logic            stack_full;
    logic            stack_empty;

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
`else
    // Without the stack, pc_address and STACK_DEPTH have no consumer.
    logic unused_inputs;
    assign unused_inputs = ^{pc_address, STACK_DEPTH[0]};
    assign stack_err     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur        <= S_IDLE;
            flagPC     <= PC_HOLD;
            newAddress <= '0;
            pc_clear   <= 1'b1;
            ir_load    <= 1'b0;
            exec_en    <= 1'b0;
            halted     <= 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
            stack_err  <= 1'b0;
            sp         <= '0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
`endif
        end else begin
            // Strobes default low; each arm raises what the next state needs.
            flagPC     <= PC_HOLD;
            newAddress <= '0;
            pc_clear   <= 1'b0;
            ir_load    <= 1'b0;
            exec_en    <= 1'b0;
            halted     <= 1'b0;

            case (cur)
                S_IDLE: begin
                    if (start) cur <= S_FETCH;
                    else       pc_clear <= 1'b1;
                end

                S_FETCH: begin
                    if (mem_ready) begin
                        cur     <= S_DECODE;
                        ir_load <= 1'b1;
                    end
                end

                S_DECODE: begin
                    cur     <= S_EXECUTE;
                    exec_en <= 1'b1;
                end

                // The EXECUTE samples are turned straight into the UPDATE
                // command on the edge that leaves EXECUTE.
                S_EXECUTE: begin
                    if (ctl_t'(ctl_kind) == K_HALT) begin
                        cur    <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        cur <= S_UPDATE;
                        case (ctl_t'(ctl_kind))
                            K_JUMP: begin
                                flagPC     <= PC_LOAD;
                                newAddress <= target_addr;
                            end
                            K_BRANCH: begin
                                if (branch_taken) begin
                                    flagPC     <= PC_LOAD;
                                    newAddress <= target_addr;
                                end else begin
                                    flagPC <= PC_INC;
                                end
                            end
                            K_JR: begin
                                flagPC     <= PC_LOAD;
                                newAddress <= reg_addr;
                            end
                            K_CALL: begin
                                flagPC     <= PC_LOAD;
                                newAddress <= target_addr;
`ifdef PC_SEQ_CALL_STACK_EN
                                // On overflow the jump still happens; only
                                // the push is lost.
                                if (stack_full) begin
                                    stack_err <= 1'b1;
                                end else begin
                                    stack_mem[IDX_W'(sp)] <= pc_address + ADDR'(1);
                                    sp <= sp + SP_W'(1);
                                end
`endif
                            end
                            K_RET: begin
`ifdef PC_SEQ_CALL_STACK_EN
                                if (stack_empty) begin
                                    flagPC    <= PC_INC;
                                    stack_err <= 1'b1;
                                end else begin
                                    flagPC     <= PC_LOAD;
                                    newAddress <= stack_mem[IDX_W'(sp - SP_W'(1))];
                                    sp         <= sp - SP_W'(1);
                                end
`else
                                flagPC <= PC_INC;
`endif
                            end
                            default: flagPC <= PC_INC;
                        endcase
                    end
                end

                S_UPDATE: cur <= S_FETCH;

                S_HALT: begin
                    if (start) cur <= S_FETCH;
                    else       halted <= 1'b1;
                end

                default: begin
                    cur      <= S_IDLE;
                    pc_clear <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int unsigned FLAG        = 2;
    localparam int unsigned ADDR        = 20;
    localparam int unsigned STACK_DEPTH = 4;

    logic            clock        = 1'b0;
    logic            reset        = 1'b0;
    logic            start        = 1'b0;
    logic [ADDR-1:0] pc_address   = '0;
    logic            mem_ready    = 1'b0;
    logic [2:0]      ctl_kind     = 3'd0;
    logic            branch_taken = 1'b0;
    logic [ADDR-1:0] target_addr  = '0;
    logic [ADDR-1:0] reg_addr     = '0;
    logic [FLAG-1:0] flagPC;
    logic [ADDR-1:0] newAddress;
    logic            pc_clear;
    logic            ir_load;
    logic            exec_en;
    logic            halted;
    logic [2:0]      state;
    logic            stack_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    pc_sequencer #(
        .FLAG        (FLAG),
        .ADDR        (ADDR),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pc_address   (pc_address),
        .mem_ready    (mem_ready),
        .ctl_kind     (ctl_kind),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .reg_addr     (reg_addr),
        .flagPC       (flagPC),
        .newAddress   (newAddress),
        .pc_clear     (pc_clear),
        .ir_load      (ir_load),
        .exec_en      (exec_en),
        .halted       (halted),
        .state        (state),
        .stack_err    (stack_err)
    );

    // Advance n rising edges; inputs driven and outputs sampled 1 time unit later.
    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_reset;
        reset     = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    // Reset, then start: leaves the DUT in FETCH with mem_ready high.
    task automatic start_run;
        apply_reset;
        start     = 1'b1;
        mem_ready = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        start     = 1'b1;
        mem_ready = 1'b1;
        tick(2);
        compared++;
        if (state !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        compared++;
        if ({pc_clear, ir_load, exec_en, halted, stack_err} !== 5'b10000) begin
            mismatched++;
            $display("FAIL reset_strobes: got %b expected 10000",
                     {pc_clear, ir_load, exec_en, halted, stack_err});
        end
        compared++;
        if ({flagPC, newAddress} !== {2'd0, 20'h00000}) begin
            mismatched++;
            $display("FAIL reset_pccmd: got flag=%0d addr=%h expected 0/00000", flagPC, newAddress);
        end
        reset = 1'b1;
        start = 1'b0;
        tick(3);
        compared++;
        if ({state, pc_clear} !== {3'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL idle_hold: got state=%0d pc_clear=%b expected 0/1", state, pc_clear);
        end
        start = 1'b1;
        tick(1);
        compared++;
        if ({state, pc_clear} !== {3'd1, 1'b0}) begin
            mismatched++;
            $display("FAIL idle_start: got state=%0d pc_clear=%b expected 1/0", state, pc_clear);
        end
        start = 1'b0;
    endtask

    // Seq stream with start held high throughout (ignored outside IDLE/HALT).
    task automatic test_sequential;
        logic [2:0]      exp_st [4];
        logic [FLAG-1:0] exp_fl [4];
        exp_st = '{3'd4, 3'd1, 3'd2, 3'd3};
        exp_fl = '{2'd1, 2'd0, 2'd0, 2'd0};
        apply_reset;
        ctl_kind  = 3'd0;
        mem_ready = 1'b1;
        start     = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            compared++;
            if ({state, flagPC, newAddress, pc_clear} !== {exp_st[k % 4], exp_fl[k % 4], 20'h00000, 1'b0}) begin
                mismatched++;
                $display("FAIL seq_cycle%0d: got state=%0d flag=%0d addr=%h clr=%b expected %0d/%0d/00000/0",
                         k, state, flagPC, newAddress, pc_clear, exp_st[k % 4], exp_fl[k % 4]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_fetch_stall;
        start_run;
        mem_ready = 1'b0;
        ctl_kind  = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            compared++;
            if ({state, ir_load, flagPC} !== {3'd1, 1'b0, 2'd0}) begin
                mismatched++;
                $display("FAIL stall_cycle%0d: got state=%0d ir_load=%b flag=%0d expected 1/0/0",
                         k, state, ir_load, flagPC);
            end
        end
        mem_ready = 1'b1;
        tick(1);
        compared++;
        if ({state, ir_load, flagPC} !== {3'd2, 1'b1, 2'd0}) begin
            mismatched++;
            $display("FAIL stall_ready: got state=%0d ir_load=%b flag=%0d expected 2/1/0", state, ir_load, flagPC);
        end
        tick(1);
        compared++;
        if ({state, ir_load, exec_en} !== {3'd3, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL stall_exec: got state=%0d ir_load=%b exec_en=%b expected 3/0/1", state, ir_load, exec_en);
        end
    endtask

    task automatic test_branch;
        start_run;
        ctl_kind     = 3'd2;
        target_addr  = 20'h00123;
        branch_taken = 1'b1;
        tick(3);
        compared++;
        if ({state, flagPC, newAddress} !== {3'd4, 2'd2, 20'h00123}) begin
            mismatched++;
            $display("FAIL branch_taken: got state=%0d flag=%0d addr=%h expected 4/2/00123", state, flagPC, newAddress);
        end
        branch_taken = 1'b0;
        tick(1);
        compared++;
        if ({state, flagPC, newAddress} !== {3'd1, 2'd0, 20'h00000}) begin
            mismatched++;
            $display("FAIL branch_after: got state=%0d flag=%0d addr=%h expected 1/0/00000", state, flagPC, newAddress);
        end
        tick(3);
        compared++;
        if ({flagPC, newAddress} !== {2'd1, 20'h00000}) begin
            mismatched++;
            $display("FAIL branch_not_taken: got flag=%0d addr=%h expected 1/00000", flagPC, newAddress);
        end
    endtask

    task automatic test_jumps;
        start_run;
        ctl_kind    = 3'd1;
        target_addr = 20'h00050;
        reg_addr    = 20'hABCDE;
        tick(3);
        compared++;
        if ({flagPC, newAddress} !== {2'd2, 20'h00050}) begin
            mismatched++;
            $display("FAIL jump: got flag=%0d addr=%h expected 2/00050", flagPC, newAddress);
        end
        ctl_kind = 3'd3;
        tick(4);
        compared++;
        if ({flagPC, newAddress} !== {2'd2, 20'hABCDE}) begin
            mismatched++;
            $display("FAIL jr: got flag=%0d addr=%h expected 2/abcde", flagPC, newAddress);
        end
        ctl_kind = 3'd7;
        tick(4);
        compared++;
        if ({flagPC, newAddress} !== {2'd1, 20'h00000}) begin
            mismatched++;
            $display("FAIL reserved: got flag=%0d addr=%h expected 1/00000", flagPC, newAddress);
        end
    endtask

    task automatic test_call_ret;
        start_run;
        pc_address  = 20'hFFFFF;
        ctl_kind    = 3'd4;
        target_addr = 20'h00010;
        tick(3);
        compared++;
        if ({flagPC, newAddress} !== {2'd2, 20'h00010}) begin
            mismatched++;
            $display("FAIL call: got flag=%0d addr=%h expected 2/00010", flagPC, newAddress);
        end
        pc_address = 20'h00010;
        ctl_kind   = 3'd5;
        tick(4);
`ifdef PC_SEQ_CALL_STACK_EN
        compared++;
        if ({flagPC, newAddress, stack_err} !== {2'd2, 20'h00000, 1'b0}) begin
            mismatched++;
            $display("FAIL ret_wrap: got flag=%0d addr=%h err=%b expected 2/00000/0", flagPC, newAddress, stack_err);
        end
        // Five nested calls into a four-deep stack, then unwind.
        start_run;
        for (int i = 0; i < 5; i++) begin
            pc_address  = 20'h00100 + 20'(i);
            target_addr = 20'h00200 + 20'(i);
            ctl_kind    = 3'd4;
            tick(3);
            compared++;
            if ({flagPC, newAddress, stack_err} !== {2'd2, 20'h00200 + 20'(i), (i == 4)}) begin
                mismatched++;
                $display("FAIL nest_call%0d: got flag=%0d addr=%h err=%b expected 2/%h/%b",
                         i, flagPC, newAddress, stack_err, 20'h00200 + 20'(i), (i == 4));
            end
            tick(1);
        end
        for (int i = 0; i < 4; i++) begin
            ctl_kind = 3'd5;
            tick(3);
            compared++;
            if ({flagPC, newAddress, stack_err} !== {2'd2, 20'h00104 - 20'(i), 1'b1}) begin
                mismatched++;
                $display("FAIL nest_ret%0d: got flag=%0d addr=%h err=%b expected 2/%h/1",
                         i, flagPC, newAddress, stack_err, 20'h00104 - 20'(i));
            end
            tick(1);
        end
        // Underflow from a clean reset, then stickiness across a seq.
        start_run;
        ctl_kind = 3'd5;
        tick(3);
        compared++;
        if ({flagPC, newAddress, stack_err} !== {2'd1, 20'h00000, 1'b1}) begin
            mismatched++;
            $display("FAIL underflow: got flag=%0d addr=%h err=%b expected 1/00000/1", flagPC, newAddress, stack_err);
        end
        ctl_kind = 3'd0;
        tick(4);
        compared++;
        if ({flagPC, stack_err} !== {2'd1, 1'b1}) begin
            mismatched++;
            $display("FAIL err_sticky: got flag=%0d err=%b expected 1/1", flagPC, stack_err);
        end
`else
        compared++;
        if ({flagPC, newAddress, stack_err} !== {2'd1, 20'h00000, 1'b0}) begin
            mismatched++;
            $display("FAIL ret_as_seq: got flag=%0d addr=%h err=%b expected 1/00000/0", flagPC, newAddress, stack_err);
        end
`endif
    endtask

    task automatic test_halt;
        start_run;
        ctl_kind = 3'd6;
        tick(3);
        compared++;
        if ({state, halted, flagPC, newAddress} !== {3'd5, 1'b1, 2'd0, 20'h00000}) begin
            mismatched++;
            $display("FAIL halt_enter: got state=%0d halted=%b flag=%0d addr=%h expected 5/1/0/00000",
                     state, halted, flagPC, newAddress);
        end
        ctl_kind = 3'd0;
        tick(6);
        compared++;
        if ({state, halted, flagPC} !== {3'd5, 1'b1, 2'd0}) begin
            mismatched++;
            $display("FAIL halt_hold: got state=%0d halted=%b flag=%0d expected 5/1/0", state, halted, flagPC);
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        compared++;
        if ({state, halted, pc_clear} !== {3'd1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL halt_resume: got state=%0d halted=%b clr=%b expected 1/0/0", state, halted, pc_clear);
        end
        tick(3);
        compared++;
        if ({state, flagPC} !== {3'd4, 2'd1}) begin
            mismatched++;
            $display("FAIL resume_update: got state=%0d flag=%0d expected 4/1", state, flagPC);
        end
    endtask

    task automatic test_reset_midflight;
        start_run;
        ctl_kind    = 3'd1;
        target_addr = 20'h00050;
        tick(2);
        compared++;
        if ({state, exec_en} !== {3'd3, 1'b1}) begin
            mismatched++;
            $display("FAIL mid_exec: got state=%0d exec_en=%b expected 3/1", state, exec_en);
        end
        reset = 1'b0;
        #1;
        compared++;
        if ({state, pc_clear, flagPC, exec_en} !== {3'd0, 1'b1, 2'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_exec_reset: got state=%0d clr=%b flag=%0d exec_en=%b expected 0/1/0/0",
                     state, pc_clear, flagPC, exec_en);
        end
        for (int k = 1; k <= 2; k++) begin
            tick(1);
            compared++;
            if ({state, flagPC} !== {3'd0, 2'd0}) begin
                mismatched++;
                $display("FAIL mid_exec_hold%0d: got state=%0d flag=%0d expected 0/0", k, state, flagPC);
            end
        end
        start_run;
        tick(3);
        compared++;
        if ({state, flagPC, newAddress} !== {3'd4, 2'd2, 20'h00050}) begin
            mismatched++;
            $display("FAIL mid_update_pre: got state=%0d flag=%0d addr=%h expected 4/2/00050", state, flagPC, newAddress);
        end
        reset = 1'b0;
        #1;
        compared++;
        if ({state, flagPC, newAddress, pc_clear} !== {3'd0, 2'd0, 20'h00000, 1'b1}) begin
            mismatched++;
            $display("FAIL mid_update_reset: got state=%0d flag=%0d addr=%h clr=%b expected 0/0/00000/1",
                     state, flagPC, newAddress, pc_clear);
        end
        tick(1);
        reset = 1'b1;
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_fetch_stall;
        test_branch;
        test_jumps;
        test_call_ret;
        test_halt;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
